// File: rtl/pipe_defs.sv
// Shared encodings for the pipeline hazard/stall sequencer: PC redirect
// selects, ID operand forwarding selects, sequencer states and the two
// canonical control-strobe bundles used by the sequencer.
package pipe_defs;

  // PC source select
  localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JUMP   = 2'd2;

  // ID operand source select
  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  // Register 0 is hardwired and never takes part in hazards or forwarding
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DWAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       if_id_we;
    logic       id_ex_we;
    logic       ex_mem_we;
    logic       mem_wb_we;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_mem_flush;
  } ctrl_t;

  // Whole pipeline frozen: nothing written, nothing flushed
  localparam ctrl_t CTRL_HOLD = '{
    pc_we: 1'b0, pc_sel: PC_SEL_SEQ, if_id_we: 1'b0, id_ex_we: 1'b0,
    ex_mem_we: 1'b0, mem_wb_we: 1'b0, if_id_flush: 1'b0,
    id_ex_flush: 1'b0, ex_mem_flush: 1'b0
  };

  // Pipeline advancing sequentially with no bubbles
  localparam ctrl_t CTRL_FLOW = '{
    pc_we: 1'b1, pc_sel: PC_SEL_SEQ, if_id_we: 1'b1, id_ex_we: 1'b1,
    ex_mem_we: 1'b1, mem_wb_we: 1'b1, if_id_flush: 1'b0,
    id_ex_flush: 1'b0, ex_mem_flush: 1'b0
  };

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding comparator for one ID-stage source register.
// The EX-stage result is newer than the EX/MEM one, so it wins.
module fwd_select
  import pipe_defs::*;
(
  input  logic [4:0] id_reg,
  input  logic [4:0] ex_reg_probe,
  input  logic       ex_write_probe,
  input  logic [4:0] mem_reg_addr,
  input  logic       mem_reg_write,
  output logic [1:0] fwd
);

  // Pick the newest in-flight producer of id_reg, ignoring register 0
  always_comb begin
    fwd = FWD_REG;
    if ((id_reg != REG_ZERO) && ex_write_probe && (ex_reg_probe == id_reg)) begin
      fwd = FWD_EX;
    end else if ((id_reg != REG_ZERO) && mem_reg_write && (mem_reg_addr == id_reg)) begin
      fwd = FWD_MEM;
    end else begin
      fwd = FWD_REG;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline. Produces per-stage
// register enables, bubble strobes, PC redirect select and ID forwarding
// selects; owns the data-memory wait state, its timeout flag and a count of
// cycles in which the PC was held.
module pipeline_ctrl
  import pipe_defs::*;
#(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned WAIT_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_reg_s,
  input  logic [4:0]  id_reg_t,
  input  logic        id_uses_s,
  input  logic        id_uses_t,
  input  logic [4:0]  ex_reg_probe,
  input  logic        ex_write_probe,
  input  logic        ex_mem_read,
  input  logic [4:0]  mem_reg_addr,
  input  logic        mem_reg_write,
  input  logic        mem_is_branch,
  input  logic        mem_alu_zero,
  input  logic        mem_is_jump,
  input  logic        mem_access,
  input  logic        dmem_ready,
  input  logic        imem_ready,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        if_id_we,
  output logic        id_ex_we,
  output logic        ex_mem_we,
  output logic        mem_wb_we,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic [1:0]  fwd_s,
  output logic [1:0]  fwd_t,
  output logic [31:0] stall_count,
  output logic        timeout
);

  localparam logic [WAIT_W-1:0] WAIT_ZERO  = {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0] WAIT_ONE   = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [WAIT_W-1:0] WAIT_SAT   = {WAIT_W{1'b1}};
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
  localparam logic [31:0]       STALL_SAT  = 32'hFFFF_FFFF;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]       stall_count_q, stall_count_d;
  logic              timeout_q, timeout_d;

  ctrl_t             ctrl_s;
  ctrl_t             ctrl_out_s;
  logic [1:0]        fwd_s_raw, fwd_t_raw;

  logic freeze_s;
  logic redirect_s;
  logic load_use_s;

  assign freeze_s   = mem_access & ~dmem_ready;
  assign redirect_s = mem_is_jump | (mem_is_branch & mem_alu_zero);
  assign load_use_s = ex_mem_read & (ex_reg_probe != REG_ZERO) &
                      (((ex_reg_probe == id_reg_s) & id_uses_s) |
                       ((ex_reg_probe == id_reg_t) & id_uses_t));

  fwd_select u_fwd_rs (
    .id_reg         (id_reg_s),
    .ex_reg_probe   (ex_reg_probe),
    .ex_write_probe (ex_write_probe),
    .mem_reg_addr   (mem_reg_addr),
    .mem_reg_write  (mem_reg_write),
    .fwd            (fwd_s_raw)
  );

  fwd_select u_fwd_rt (
    .id_reg         (id_reg_t),
    .ex_reg_probe   (ex_reg_probe),
    .ex_write_probe (ex_write_probe),
    .mem_reg_addr   (mem_reg_addr),
    .mem_reg_write  (mem_reg_write),
    .fwd            (fwd_t_raw)
  );

  // Next-state and control strobes, hazards evaluated in priority order
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    ctrl_s     = CTRL_HOLD;
    case (state_q)
      ST_RUN: begin
        if (freeze_s) begin
          ctrl_s     = CTRL_HOLD;
          state_d    = ST_DWAIT;
          wait_cnt_d = WAIT_ONE;
        end else if (redirect_s) begin
          ctrl_s              = CTRL_FLOW;
          ctrl_s.pc_sel       = mem_is_jump ? PC_SEL_JUMP : PC_SEL_BRANCH;
          ctrl_s.if_id_flush  = 1'b1;
          ctrl_s.id_ex_flush  = 1'b1;
          ctrl_s.ex_mem_flush = 1'b1;
        end else if (load_use_s) begin
          ctrl_s             = CTRL_FLOW;
          ctrl_s.pc_we       = 1'b0;
          ctrl_s.if_id_we    = 1'b0;
          ctrl_s.id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
          ctrl_s             = CTRL_FLOW;
          ctrl_s.pc_we       = 1'b0;
          ctrl_s.if_id_flush = 1'b1;
        end else begin
          ctrl_s = CTRL_FLOW;
        end
      end
      ST_DWAIT: begin
        // The completing cycle still freezes; hazards are re-evaluated in RUN
        ctrl_s = CTRL_HOLD;
        if (dmem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = WAIT_ZERO;
        end else begin
          if (wait_cnt_q != WAIT_SAT) begin
            wait_cnt_d = wait_cnt_q + WAIT_ONE;
          end else begin
            wait_cnt_d = wait_cnt_q;
          end
          if (wait_cnt_q >= MAX_WAIT_C) begin
            timeout_d = 1'b1;
          end else begin
            timeout_d = timeout_q;
          end
        end
      end
      default: begin
        ctrl_s     = CTRL_HOLD;
        state_d    = ST_RUN;
        wait_cnt_d = WAIT_ZERO;
      end
    endcase
  end

  // Reset forces every combinational control output to zero
  always_comb begin
    if (reset) begin
      ctrl_out_s = CTRL_HOLD;
      fwd_s      = FWD_REG;
      fwd_t      = FWD_REG;
    end else begin
      ctrl_out_s = ctrl_s;
      fwd_s      = fwd_s_raw;
      fwd_t      = fwd_t_raw;
    end
  end

  // Saturating count of cycles where the PC is held
  always_comb begin
    if (!ctrl_out_s.pc_we && (stall_count_q != STALL_SAT)) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= WAIT_ZERO;
      stall_count_q <= 32'd0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
      timeout_q     <= timeout_d;
    end
  end

  assign pc_we        = ctrl_out_s.pc_we;
  assign pc_sel       = ctrl_out_s.pc_sel;
  assign if_id_we     = ctrl_out_s.if_id_we;
  assign id_ex_we     = ctrl_out_s.id_ex_we;
  assign ex_mem_we    = ctrl_out_s.ex_mem_we;
  assign mem_wb_we    = ctrl_out_s.mem_wb_we;
  assign if_id_flush  = ctrl_out_s.if_id_flush;
  assign id_ex_flush  = ctrl_out_s.id_ex_flush;
  assign ex_mem_flush = ctrl_out_s.ex_mem_flush;
  assign stall_count  = stall_count_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vectors, a behavioural model checked on
// every negedge, and literal expectations at key points.
module tb_pipeline_ctrl;

  localparam int MAXW = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_reg_s, id_reg_t, ex_reg_probe, mem_reg_addr;
  logic        id_uses_s, id_uses_t, ex_write_probe, ex_mem_read;
  logic        mem_reg_write, mem_is_branch, mem_alu_zero, mem_is_jump;
  logic        mem_access, dmem_ready, imem_ready;
  logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, timeout;
  logic [1:0]  pc_sel, fwd_s, fwd_t;
  logic [31:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_ctrl #(.MAX_WAIT(MAXW), .WAIT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_reg_s(id_reg_s), .id_reg_t(id_reg_t),
    .id_uses_s(id_uses_s), .id_uses_t(id_uses_t),
    .ex_reg_probe(ex_reg_probe), .ex_write_probe(ex_write_probe),
    .ex_mem_read(ex_mem_read), .mem_reg_addr(mem_reg_addr),
    .mem_reg_write(mem_reg_write), .mem_is_branch(mem_is_branch),
    .mem_alu_zero(mem_alu_zero), .mem_is_jump(mem_is_jump),
    .mem_access(mem_access), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
    .pc_we(pc_we), .pc_sel(pc_sel), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
    .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .fwd_s(fwd_s), .fwd_t(fwd_t),
    .stall_count(stall_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int pc_we, pc_sel, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    int if_id_flush, id_ex_flush, ex_mem_flush, fwd_s, fwd_t;
  } exp_t;

  bit          m_valid   = 1'b0;
  bit          m_waiting = 1'b0;
  int          m_wait    = 0;
  longint      m_stall   = 0;
  bit          m_to      = 1'b0;

  function automatic int fwd_of(input logic [4:0] r);
    if (r == 0) return 0;
    if (ex_write_probe && ex_reg_probe == r) return 1;
    if (mem_reg_write && mem_reg_addr == r) return 2;
    return 0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    bit lu;
    e = '{default: 0};
    if (reset) return e;
    e.fwd_s = fwd_of(id_reg_s);
    e.fwd_t = fwd_of(id_reg_t);
    if (m_waiting || (mem_access && !dmem_ready)) return e;
    // pipeline moving: start with every register enabled
    e.pc_we = 1; e.if_id_we = 1; e.id_ex_we = 1; e.ex_mem_we = 1; e.mem_wb_we = 1;
    lu = ex_mem_read && ex_reg_probe != 0 &&
         ((ex_reg_probe == id_reg_s && id_uses_s) || (ex_reg_probe == id_reg_t && id_uses_t));
    if (mem_is_jump || (mem_is_branch && mem_alu_zero)) begin
      e.pc_sel = mem_is_jump ? 2 : 1;
      e.if_id_flush = 1; e.id_ex_flush = 1; e.ex_mem_flush = 1;
    end else if (lu) begin
      e.pc_we = 0; e.if_id_we = 0; e.id_ex_flush = 1;
    end else if (!imem_ready) begin
      e.pc_we = 0; e.if_id_flush = 1;
    end
    return e;
  endfunction

  // Advance the model's state at each active edge
  always @(posedge clk) begin
    exp_t e;
    e = model_out();
    if (reset) begin
      m_valid <= 1'b1; m_waiting <= 1'b0; m_wait <= 0; m_stall <= 0; m_to <= 1'b0;
    end else if (m_valid) begin
      if (e.pc_we == 0 && m_stall < 64'hFFFF_FFFF) m_stall <= m_stall + 1;
      if (!m_waiting) begin
        if (mem_access && !dmem_ready) begin
          m_waiting <= 1'b1; m_wait <= 1;
        end
      end else if (dmem_ready) begin
        m_waiting <= 1'b0; m_wait <= 0;
      end else begin
        if (m_wait >= MAXW) m_to <= 1'b1;
        m_wait <= (m_wait < 65535) ? m_wait + 1 : m_wait;
      end
    end
  end

  // Compare every output against the model away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (m_valid) begin
      e = model_out();
      check("pc_we",        64'(pc_we),        64'(e.pc_we));
      check("pc_sel",       64'(pc_sel),       64'(e.pc_sel));
      check("if_id_we",     64'(if_id_we),     64'(e.if_id_we));
      check("id_ex_we",     64'(id_ex_we),     64'(e.id_ex_we));
      check("ex_mem_we",    64'(ex_mem_we),    64'(e.ex_mem_we));
      check("mem_wb_we",    64'(mem_wb_we),    64'(e.mem_wb_we));
      check("if_id_flush",  64'(if_id_flush),  64'(e.if_id_flush));
      check("id_ex_flush",  64'(id_ex_flush),  64'(e.id_ex_flush));
      check("ex_mem_flush", 64'(ex_mem_flush), 64'(e.ex_mem_flush));
      check("fwd_s",        64'(fwd_s),        64'(e.fwd_s));
      check("fwd_t",        64'(fwd_t),        64'(e.fwd_t));
      check("stall_count",  64'(stall_count),  64'(m_stall));
      check("timeout",      64'(timeout),      64'(m_to));
    end
  end

  // ---------------- stimulus ----------------
  task automatic quiet();
    id_reg_s = 5'd0; id_reg_t = 5'd0; id_uses_s = 1'b0; id_uses_t = 1'b0;
    ex_reg_probe = 5'd0; ex_write_probe = 1'b0; ex_mem_read = 1'b0;
    mem_reg_addr = 5'd0; mem_reg_write = 1'b0; mem_is_branch = 1'b0;
    mem_alu_zero = 1'b0; mem_is_jump = 1'b0; mem_access = 1'b0;
    dmem_ready = 1'b1; imem_ready = 1'b1;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    next(); reset = 1'b1; quiet();
    next(); reset = 1'b0;
  endtask

  initial begin
    // Reset held with every input active
    reset = 1'b1;
    id_reg_s = 5'd5; id_reg_t = 5'd5; id_uses_s = 1'b1; id_uses_t = 1'b1;
    ex_reg_probe = 5'd5; ex_write_probe = 1'b1; ex_mem_read = 1'b1;
    mem_reg_addr = 5'd5; mem_reg_write = 1'b1; mem_is_branch = 1'b1;
    mem_alu_zero = 1'b1; mem_is_jump = 1'b1; mem_access = 1'b1;
    dmem_ready = 1'b0; imem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1; sample();
    check("rst_pc_we", 64'(pc_we), 64'd0);
    check("rst_flush", 64'({if_id_flush, id_ex_flush, ex_mem_flush}), 64'd0);
    check("rst_stall", 64'(stall_count), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);

    // First cycle after release, quiet inputs
    next(); reset = 1'b0; quiet(); sample();
    check("run_we", 64'({pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}), 64'h1F);
    check("run_pc_sel", 64'(pc_sel), 64'd0);

    // Load-use on rs
    next(); ex_mem_read = 1'b1; ex_reg_probe = 5'd5; id_reg_s = 5'd5; id_uses_s = 1'b1;
    sample();
    check("lu_pc_we", 64'(pc_we), 64'd0);
    check("lu_if_id_we", 64'(if_id_we), 64'd0);
    check("lu_id_ex_flush", 64'(id_ex_flush), 64'd1);

    // Register 0 never hazards
    next(); ex_reg_probe = 5'd0; id_reg_s = 5'd0; sample();
    check("lu_stall_cnt", 64'(stall_count), 64'd1);
    check("r0_pc_we", 64'(pc_we), 64'd1);

    // Load-use on rt, then same with rt not read
    next(); ex_reg_probe = 5'd9; id_reg_t = 5'd9; id_uses_t = 1'b1; id_uses_s = 1'b0; sample();
    next(); id_uses_t = 1'b0; sample();

    // Taken branch beats a simultaneous load-use
    next(); id_uses_t = 1'b1; mem_is_branch = 1'b1; mem_alu_zero = 1'b1; sample();
    check("br_pc_sel", 64'(pc_sel), 64'd1);
    check("br_flushes", 64'({if_id_flush, id_ex_flush, ex_mem_flush}), 64'h7);
    check("br_pc_we", 64'(pc_we), 64'd1);
    next(); mem_is_jump = 1'b1; sample();
    check("jmp_pc_sel", 64'(pc_sel), 64'd2);
    next(); mem_is_branch = 1'b1; mem_alu_zero = 1'b0; mem_is_jump = 1'b0; sample();

    // Instruction memory miss
    next(); quiet(); imem_ready = 1'b0; sample();
    check("im_if_id_flush", 64'(if_id_flush), 64'd1);
    check("im_pc_we", 64'(pc_we), 64'd0);

    // Forwarding
    next(); quiet(); ex_write_probe = 1'b1; ex_reg_probe = 5'd7; mem_reg_write = 1'b1;
    mem_reg_addr = 5'd7; id_reg_s = 5'd7; id_reg_t = 5'd7; sample();
    check("fwd_ex", 64'({fwd_s, fwd_t}), 64'h5);
    next(); ex_write_probe = 1'b0; sample();
    check("fwd_mem", 64'({fwd_s, fwd_t}), 64'hA);
    next(); ex_write_probe = 1'b1; ex_reg_probe = 5'd7; mem_reg_addr = 5'd3; id_reg_t = 5'd3; sample();
    next(); ex_reg_probe = 5'd0; mem_reg_addr = 5'd0; id_reg_s = 5'd0; id_reg_t = 5'd0; sample();
    check("fwd_r0", 64'({fwd_s, fwd_t}), 64'h0);

    // Data memory wait: 4 not-ready cycles then ready
    reset_pulse();
    mem_access = 1'b1; dmem_ready = 1'b0; sample();
    for (int i = 0; i < 3; i++) begin
      next(); sample();
    end
    next(); dmem_ready = 1'b1; mem_is_jump = 1'b1; sample();
    check("dw_last_frozen", 64'(pc_we), 64'd0);
    next(); quiet(); sample();
    check("dw_resume_we", 64'({pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}), 64'h1F);
    check("dw_stall_cnt", 64'(stall_count), 64'd5);

    // Timeout with MAX_WAIT = 3
    reset_pulse();
    mem_access = 1'b1; dmem_ready = 1'b0; sample();
    check("to_run", 64'(timeout), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      next(); sample();
      check("to_pending", 64'(timeout), 64'd0);
    end
    next(); sample();
    check("to_rise", 64'(timeout), 64'd1);
    next(); next(); sample();
    check("to_sticky", 64'(timeout), 64'd1);
    next(); dmem_ready = 1'b1; sample();
    next(); quiet(); sample();
    check("to_after_run", 64'(timeout), 64'd1);
    check("to_run_pc_we", 64'(pc_we), 64'd1);
    reset_pulse(); sample();
    check("to_cleared", 64'(timeout), 64'd0);

    next();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and stall sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Generates the per-pipeline-register write-enables (the `we` inputs of each stage) and bubble/flush strobes.
- Generates PC redirect select and ID-stage operand forwarding selects.
- Uses the EX-stage probe outputs, the EX/MEM branch/jump feedback and memory-ready handshakes.
- Owns a data-memory wait FSM with timeout detection and a stall performance counter.

Parameters:
MAX_WAIT, 255, max consecutive dmem wait cycles before timeout asserts (1..65535)
WAIT_W, 16, width of the internal wait counter; must hold MAX_WAIT

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_reg_s  in  5  rs of instruction in ID
id_reg_t  in  5  rt of instruction in ID
id_uses_s  in  1  ID instruction reads rs
id_uses_t  in  1  ID instruction reads rt
ex_reg_probe  in  5  destination reg of instruction in EX
ex_write_probe  in  1  EX instruction writes a reg with an ALU result (not a load)
ex_mem_read  in  1  EX instruction is a load
mem_reg_addr  in  5  destination reg held in EX/MEM
mem_reg_write  in  1  EX/MEM reg_write
mem_is_branch  in  1  EX/MEM is_branch_out
mem_alu_zero  in  1  EX/MEM alu_zero
mem_is_jump  in  1  EX/MEM is_jump_out
mem_access  in  1  EX/MEM mem_read_out | mem_write_out
dmem_ready  in  1  data memory completes access this cycle
imem_ready  in  1  instruction memory returns valid word this cycle
pc_we  out  1  PC register enable
pc_sel  out  2  0 sequential, 1 pc_branch, 2 pc_jump_out
if_id_we  out  1  IF/ID enable
id_ex_we  out  1  ID/EX enable
ex_mem_we  out  1  EX/MEM enable (ex_stage we)
mem_wb_we  out  1  MEM/WB enable
if_id_flush  out  1  load bubble into IF/ID
id_ex_flush  out  1  load bubble into ID/EX
ex_mem_flush  out  1  load bubble into EX/MEM
fwd_s  out  2  ID rs source: 0 regfile, 1 EX probe data, 2 EX/MEM alu_out
fwd_t  out  2  ID rt source, same encoding
stall_count  out  32  cycles with pc_we=0 since reset
timeout  out  1  sticky dmem timeout flag

Behaviour:
- Reset, state, and control outputs:
  - reset dominates: state=RUN, wait_cnt=0, stall_count=0, timeout=0.
  - All combinational control outputs are forced to 0 during reset, including all enables and flushes.
- Register 0 never matches for hazards or forwarding.
- The FSM has two states, RUN and DWAIT.
- Evaluation priority in RUN, highest first:
  - 1. dmem freeze:
    - Condition: mem_access & !dmem_ready.
    - All we=0, no flushes.
    - Next state DWAIT, wait_cnt=1.
  - 2. redirect:
    - Condition: mem_is_jump | (mem_is_branch & mem_alu_zero).
    - pc_we=1, pc_sel=2 if mem_is_jump else 1.
    - if_id_flush, id_ex_flush, ex_mem_flush =1.
    - mem_wb_we=1.
    - Jump wins over branch.
  - 3. load-use:
    - Condition: ex_mem_read & (ex_reg_probe==id_reg_s & id_uses_s | ex_reg_probe==id_reg_t & id_uses_t).
    - pc_we=if_id_we=0, id_ex_flush=1.
    - ex_mem_we=mem_wb_we=1.
  - 4. imem miss:
    - Condition: !imem_ready.
    - pc_we=0, if_id_flush=1.
    - Downstream enables =1.
  - 5. normal: all we=1, pc_sel=0, no flushes.
- Enable/flush relationship:
  - A flush strobe is valid only with its register's we=1.
  - The flushed register loads a NOP (all control fields 0).
- DWAIT:
  - All we=0, all flushes 0.
  - If dmem_ready, the current cycle still freezes; next state RUN, wait_cnt=0.
  - Redirect and load-use are re-evaluated in RUN on the following cycle. The frozen registers preserve their inputs.
  - Else wait_cnt increments, saturating.
  - When wait_cnt reaches MAX_WAIT with dmem_ready=0, timeout<=1. Timeout is sticky until reset and the FSM stays in DWAIT.
- Forwarding (combinational, independent of state):
  - fwd_s=1 if ex_write_probe & ex_reg_probe==id_reg_s.
  - Else fwd_s=2 if mem_reg_write & mem_reg_addr==id_reg_s.
  - Else 0. EX has priority as the newer value. fwd_t is identical on rt.
- stall_count increments every non-reset cycle with pc_we=0 and saturates at 32'hFFFF_FFFF.
- All outputs other than stall_count, timeout, and state are combinational from inputs and state. Zero latency.

Decomposition:
- Shared package/header `pipe_defs`:
  - PC_SEL_SEQ/BRANCH/JUMP.
  - FWD_REG/FWD_EX/FWD_MEM.
  - State encodings RUN/DWAIT.
- One sub-module, `fwd_select`: pure comparator for one operand, instantiated twice for rs/rt.

Test Plan:
- Reset held 3 cycles with all inputs active -> all enables/flushes 0, stall_count=0, timeout=0. First cycle after release with quiet inputs -> all we=1, pc_sel=0.
- Load-use: ex_mem_read=1, ex_reg_probe=5, id_reg_s=5, id_uses_s=1 -> pc_we=0, if_id_we=0, id_ex_flush=1, stall_count +1. Same with id_reg_s=0 and probe=0 -> no stall.
- Branch taken with simultaneous load-use: mem_is_branch=1, mem_alu_zero=1 -> pc_sel=1, three flushes=1, no load-use stall. Adding mem_is_jump=1 -> pc_sel=2.
- dmem wait: mem_access=1, dmem_ready=0 for 4 cycles then 1 -> 5 cycles all we=0, then RUN with we=1, stall_count=5.
- Timeout with MAX_WAIT=3: dmem_ready held 0 -> timeout rises after the 3rd DWAIT cycle and stays 1. Later dmem_ready=1 -> RUN, timeout still 1 until reset.
- Forwarding: ex_write_probe=1, probe=7; mem_reg_write=1, addr=7; id_reg_s=id_reg_t=7 -> fwd_s=fwd_t=1. Drop ex_write_probe -> both 2.
